lcd_in_axis: RTL and testbench

Video-input counterpart of the LCD output path. It samples a parallel LCD-style video bus (vs/hs/de/rgb) and emits an AXI4-Stream master stream with frame sync on tuser and end-of-line on tlast. This matches the format the LCD display path consumes. A small show-ahead FIFO absorbs axis_tready back-pressure, because the video source cannot be stalled. The block feeds the frame-buffer/DMA writer.

---
 rtl/lcd_in_pkg.sv | 21 ++
 rtl/lcd_in_fifo.sv | 68 ++++++
 rtl/lcd_in_axis.sv | 190 +++++++++++++++++++
 tb/tb_lcd_in_axis.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_in_pkg.sv
// -----------------------------------------------------------------------------
// lcd_in_pkg
// Shared constants for the LCD video-input to AXI4-Stream bridge.
//   AXIS_DATA_W    : width of the AXI4-Stream tdata bus
//   RGB_W          : width of one {R,G,B} pixel
//   ENTRY_W        : width of one output-buffer entry {tuser, tlast, rgb}
//   AXIS_TSTRB_ALL : constant byte-strobe value
//   ENT_*          : bit positions of the fields inside a buffer entry
// -----------------------------------------------------------------------------
package lcd_in_pkg;

  localparam int         AXIS_DATA_W    = 32;
  localparam int         RGB_W          = 24;
  localparam int         ENTRY_W        = 26;
  localparam logic [3:0] AXIS_TSTRB_ALL = 4'hF;

  localparam int         ENT_RGB_LSB    = 0;
  localparam int         ENT_TLAST_BIT  = 24;
  localparam int         ENT_TUSER_BIT  = 25;

endpackage

// File: rtl/lcd_in_fifo.sv
// -----------------------------------------------------------------------------
// lcd_in_fifo
// Synchronous show-ahead FIFO. The head entry is always visible on o_rd_data;
// a pop simply advances to the next entry. A push while full is accepted when
// a pop happens in the same cycle.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   i_push       : write request, i_wr_data is the entry to store
//   o_push_ok    : write request accepted this cycle
//   i_pop        : advance the head (ignored while empty)
//   o_rd_data    : head entry (only meaningful while o_count != 0)
//   o_count      : number of stored entries
// -----------------------------------------------------------------------------
module lcd_in_fifo
  import lcd_in_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  output logic                     o_push_ok,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_pop && (r_count != '0);
  // The slot freed by a same-cycle pop makes room for the push.
  assign w_push = i_push && ((r_count < FULL_CNT) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_push_ok = w_push;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/lcd_in_axis.sv
// -----------------------------------------------------------------------------
// lcd_in_axis
// Samples a parallel LCD-style video bus and emits an AXI4-Stream master
// stream: tuser marks the first pixel of a frame, tlast the last pixel of a
// line. A show-ahead FIFO absorbs tready back-pressure; the source cannot be
// stalled, so a write that does not fit sets a sticky overflow flag and the
// rest of the frame is dropped until the next vertical sync.
// Optional build macro LCD_IN_LINE_CHECK_EN adds a sticky line-length check
// against H_ACTIVE; without it line_err is tied low.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   vin_vs/hs/de/rgb    : video input (hs is sampled by nothing)
//   axis_tdata/tvalid/tready/tuser/tlast/tstrb : AXI4-Stream master
//   ovf_clr             : clears ovf_err (and line_err)
//   ovf_err             : sticky overflow flag
//   line_err            : sticky line-length error
//   frame_cnt           : frames delivered downstream (wrapping)
// -----------------------------------------------------------------------------
module lcd_in_axis
  import lcd_in_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int H_ACTIVE       = 480,
  parameter int VS_ACTIVE_HIGH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vin_vs,
  input  logic                   vin_hs,
  input  logic                   vin_de,
  input  logic [RGB_W-1:0]       vin_rgb,
  output logic [AXIS_DATA_W-1:0] axis_tdata,
  output logic                   axis_tvalid,
  input  logic                   axis_tready,
  output logic                   axis_tuser,
  output logic                   axis_tlast,
  output logic [3:0]             axis_tstrb,
  input  logic                   ovf_clr,
  output logic                   ovf_err,
  output logic                   line_err,
  output logic [15:0]            frame_cnt
);

  localparam logic [11:0] H_ACTIVE_C = 12'(H_ACTIVE);

  logic                   w_vs_act;
  logic                   w_vs_start;
  logic                   w_cap;
  logic                   w_wr_req;
  logic                   w_push_ok;
  logic                   w_pop;
  logic                   w_ovf;
  logic [ENTRY_W-1:0]     w_entry;
  logic [ENTRY_W-1:0]     w_head;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic [12:0]            w_unused;

  logic                   r_vs_p1, r_vs_p2, r_de_p1;
  logic [RGB_W-1:0]       r_rgb_p1;
  logic                   r_vld_p2, r_tuser_p2;
  logic [RGB_W-1:0]       r_rgb_p2;
  logic                   r_armed, r_sof_pend, r_drop, r_ovf_err;
  logic [15:0]            r_frame_cnt;

  assign w_vs_act = (VS_ACTIVE_HIGH != 0) ? vin_vs : ~vin_vs;
  assign w_unused = {vin_hs, H_ACTIVE_C};

  // ---- stage 1: input sampling (vs kept as "asserted" level) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_p1 <= 1'b0;
      r_vs_p2 <= 1'b0;
      r_de_p1 <= 1'b0;
    end else begin
      r_vs_p1 <= w_vs_act;
      r_vs_p2 <= r_vs_p1;
      r_de_p1 <= vin_de;
    end
  end

  always_ff @(posedge clk) begin
    r_rgb_p1 <= vin_rgb;
  end

  assign w_vs_start = r_vs_p1 & ~r_vs_p2;
  // A pixel arriving together with the sync edge already belongs to the new frame.
  assign w_cap      = r_de_p1 & (r_armed | w_vs_start);

  // ---- stage 2: hold register, framing state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2   <= 1'b0;
      r_tuser_p2 <= 1'b0;
      r_armed    <= 1'b0;
      r_sof_pend <= 1'b0;
    end else begin
      r_vld_p2   <= w_cap;
      r_tuser_p2 <= w_cap & (r_sof_pend | w_vs_start);
      if (w_vs_start) r_armed <= 1'b1;
      if (w_cap)           r_sof_pend <= 1'b0;
      else if (w_vs_start) r_sof_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap) r_rgb_p2 <= r_rgb_p1;
  end

  // ---- stage 3: FIFO write; tlast known once stage 1 shows the next cycle ----
  assign w_wr_req = r_vld_p2 & ~r_drop;
  always_comb begin
    w_entry                              = '0;
    w_entry[ENT_TUSER_BIT]               = r_tuser_p2;
    w_entry[ENT_TLAST_BIT]               = ~r_de_p1;
    w_entry[ENT_RGB_LSB +: RGB_W]        = r_rgb_p2;
  end

  assign axis_tvalid = (w_count != '0);
  assign w_pop       = axis_tvalid & axis_tready;
  assign w_ovf       = w_wr_req & ~w_push_ok;

  lcd_in_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_wr_req),
    .i_wr_data (w_entry),
    .o_push_ok (w_push_ok),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_count   (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop      <= 1'b0;
      r_ovf_err   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      // A new frame always gets a fresh chance, even if the old frame's
      // trailing pixel overflows in the same cycle.
      if (w_vs_start) r_drop <= 1'b0;
      else if (w_ovf) r_drop <= 1'b1;
      if (w_ovf)        r_ovf_err <= 1'b1;
      else if (ovf_clr) r_ovf_err <= 1'b0;
      if (w_pop && w_head[ENT_TUSER_BIT]) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Head is masked while empty so idle outputs read as zero.
  assign axis_tdata = axis_tvalid ?
                      {{(AXIS_DATA_W-RGB_W){1'b0}}, w_head[ENT_RGB_LSB +: RGB_W]} : '0;
  assign axis_tuser = axis_tvalid & w_head[ENT_TUSER_BIT];
  assign axis_tlast = axis_tvalid & w_head[ENT_TLAST_BIT];
  assign axis_tstrb = AXIS_TSTRB_ALL;
  assign ovf_err    = r_ovf_err;
  assign frame_cnt  = r_frame_cnt;

`ifdef LCD_IN_LINE_CHECK_EN
  logic [11:0] r_line_cnt;
  logic        r_line_err;
  logic        w_line_bad;

  // Only entries that actually reach the FIFO are counted, so dropped lines
  // never produce a check.
  assign w_line_bad = w_push_ok & w_entry[ENT_TLAST_BIT] &
                      ((r_line_cnt + 12'd1) != H_ACTIVE_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_cnt <= '0;
      r_line_err <= 1'b0;
    end else begin
      if (w_vs_start)
        r_line_cnt <= '0;
      else if (w_push_ok)
        r_line_cnt <= w_entry[ENT_TLAST_BIT] ? 12'd0 : r_line_cnt + 12'd1;
      if (w_line_bad)   r_line_err <= 1'b1;
      else if (ovf_clr) r_line_err <= 1'b0;
    end
  end

  assign line_err = r_line_err;
`else
  assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_in_axis.sv
module tb_lcd_in_axis;

  localparam int DEPTH = 16;
  localparam int HACT  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vin_vs, vin_hs, vin_de;
  logic [23:0] vin_rgb;
  logic [31:0] axis_tdata;
  logic        axis_tvalid, axis_tready, axis_tuser, axis_tlast;
  logic [3:0]  axis_tstrb;
  logic        ovf_clr, ovf_err, line_err;
  logic [15:0] frame_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  lcd_in_axis #(.FIFO_DEPTH(DEPTH), .H_ACTIVE(HACT), .VS_ACTIVE_HIGH(1)) dut (
    .clk(clk), .rst_n(rst_n), .vin_vs(vin_vs), .vin_hs(vin_hs), .vin_de(vin_de),
    .vin_rgb(vin_rgb), .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid),
    .axis_tready(axis_tready), .axis_tuser(axis_tuser), .axis_tlast(axis_tlast),
    .axis_tstrb(axis_tstrb), .ovf_clr(ovf_clr), .ovf_err(ovf_err),
    .line_err(line_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required summary before limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct packed { logic [23:0] rgb; logic tuser; logic tlast; } beat_t;
  typedef struct { bit vld; logic [23:0] rgb; bit tuser; bit tlast; int fid; } pend_t;

  beat_t       m_q[$];
  beat_t       obs[$];
  logic [23:0] sent[$];
  pend_t       m_s1, m_s2;
  bit          m_prev_vs, m_armed, m_sof, m_ovf, m_lerr;
  int          m_fid, m_drop_fid, m_lcnt;
  logic [15:0] m_fcnt;
  bit          p_valid, p_ready;
  logic [33:0] p_beat;

  always @(negedge clk) begin
    bit popped, ovf_set, lset;
    if (!rst_n) begin
      m_q.delete();
      m_s1 = '{default: 0};
      m_s2 = '{default: 0};
      m_prev_vs = 0; m_armed = 0; m_sof = 0; m_ovf = 0; m_lerr = 0;
      m_fid = 0; m_drop_fid = -1; m_lcnt = 0; m_fcnt = '0;
      p_valid = 0; p_ready = 0; p_beat = '0;
    end else begin
      // outputs as left by the previous edge
      n_chk++;
      if (axis_tvalid !== (m_q.size() != 0)) begin
        n_fail++;
        $display("FAIL tvalid: got %b, expected %b", axis_tvalid, m_q.size() != 0);
      end
      if (axis_tvalid === 1'b1 && m_q.size() != 0) begin
        n_chk++;
        if ({axis_tuser, axis_tlast, axis_tdata} !== {m_q[0].tuser, m_q[0].tlast, 8'h00, m_q[0].rgb}) begin
          n_fail++;
          $display("FAIL beat: got user=%b last=%b data=%h, expected user=%b last=%b data=%h",
                   axis_tuser, axis_tlast, axis_tdata, m_q[0].tuser, m_q[0].tlast, {8'h00, m_q[0].rgb});
        end
      end
      n_chk++;
      if ({ovf_err, line_err, frame_cnt, axis_tstrb} !== {m_ovf, m_lerr, m_fcnt, 4'hF}) begin
        n_fail++;
        $display("FAIL status: got ovf=%b line=%b fcnt=%0d strb=%h, expected ovf=%b line=%b fcnt=%0d strb=f",
                 ovf_err, line_err, frame_cnt, axis_tstrb, m_ovf, m_lerr, m_fcnt);
      end
      if (p_valid && !p_ready) begin
        n_chk++;
        if (axis_tvalid !== 1'b1 || {axis_tuser, axis_tlast, axis_tdata} !== p_beat) begin
          n_fail++;
          $display("FAIL stall_stable: got valid=%b beat=%h, expected valid=1 beat=%h",
                   axis_tvalid, {axis_tuser, axis_tlast, axis_tdata}, p_beat);
        end
      end
      p_valid = (axis_tvalid === 1'b1);
      p_ready = (axis_tready === 1'b1);
      p_beat  = {axis_tuser, axis_tlast, axis_tdata};
      if (p_valid && p_ready) obs.push_back('{axis_tdata[23:0], axis_tuser, axis_tlast});

      // advance model over the coming edge
      popped = (m_q.size() != 0) && axis_tready;
      if (popped) begin
        if (m_q[0].tuser) m_fcnt++;
        void'(m_q.pop_front());
      end
      ovf_set = 0; lset = 0;
      if (m_s2.vld && m_s2.fid != m_drop_fid) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back('{m_s2.rgb, m_s2.tuser, m_s2.tlast});
          m_lcnt++;
          if (m_s2.tlast) begin
            if (m_lcnt != HACT) lset = 1;
            m_lcnt = 0;
          end
        end else begin
          ovf_set = 1;
          m_drop_fid = m_s2.fid;
        end
      end
      m_ovf = ovf_set | (m_ovf & ~ovf_clr);
`ifdef LCD_IN_LINE_CHECK_EN
      m_lerr = lset | (m_lerr & ~ovf_clr);
`else
      m_lerr = 0;
`endif
      m_s2 = m_s1;
      m_s2.tlast = !vin_de;
      if (vin_vs && !m_prev_vs) begin
        m_fid++; m_armed = 1; m_sof = 1; m_lcnt = 0;
      end
      m_prev_vs = vin_vs;
      m_s1.vld = vin_de && m_armed;
      m_s1.rgb = vin_rgb;
      m_s1.fid = m_fid;
      m_s1.tuser = 0;
      if (m_s1.vld) begin
        m_s1.tuser = m_sof;
        m_sof = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put(input bit vs, input bit de, input logic [23:0] rgb);
    tick();
    vin_vs = vs; vin_de = de; vin_rgb = rgb; vin_hs = ~de & ~vs;
  endtask

  task automatic idle(input int n);
    repeat (n) put(0, 0, 24'h0);
  endtask

  task automatic send_line(input int px, input bit rec);
    for (int i = 0; i < px; i++) begin
      logic [23:0] r;
      r = 24'($urandom);
      put(0, 1, r);
      if (rec) sent.push_back(r);
    end
  endtask

  task automatic send_frame(input int lines, input int px, input int hblank);
    put(1, 0, 24'h0); put(1, 0, 24'h0);
    idle(2);
    for (int l = 0; l < lines; l++) begin
      send_line(px, 1);
      idle(hblank);
    end
  endtask

  task automatic apply_reset();
    tick();
    rst_n = 0; vin_vs = 0; vin_de = 0; vin_hs = 0; vin_rgb = '0; ovf_clr = 0;
    repeat (3) tick();
    rst_n = 1;
    obs.delete(); sent.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    axis_tready = 0;
    send_frame(1, 8, 2);
    idle(4);
    tick();
    rst_n = 0;
    @(negedge clk);
    n_chk++;
    if ({axis_tvalid, axis_tuser, axis_tlast, axis_tdata} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_stream: got valid=%b user=%b last=%b data=%h, expected all 0",
               axis_tvalid, axis_tuser, axis_tlast, axis_tdata);
    end
    n_chk++;
    if ({ovf_err, line_err, frame_cnt, axis_tstrb} !== {18'h0, 4'hF}) begin
      n_fail++;
      $display("FAIL reset_status: got ovf=%b line=%b fcnt=%0d strb=%h, expected 0 0 0 f",
               ovf_err, line_err, frame_cnt, axis_tstrb);
    end
    tick();
    rst_n = 1;
    axis_tready = 1;
    idle(3);
  endtask

  task automatic test_basic_frames();
    apply_reset();
    axis_tready = 1;
    send_frame(4, 8, 4);
    send_frame(4, 8, 4);
    idle(20);
    n_chk++;
    if (obs.size() != 64) begin
      n_fail++; $display("FAIL basic_count: got %0d beats, expected 64", obs.size());
    end
    for (int i = 0; i < obs.size() && i < 64; i++) begin
      n_chk++;
      if ({obs[i].tuser, obs[i].tlast, obs[i].rgb} !== {(i == 0 || i == 32), (i % 8 == 7), sent[i]}) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got user=%b last=%b rgb=%h, expected user=%b last=%b rgb=%h",
                 i, obs[i].tuser, obs[i].tlast, obs[i].rgb, (i == 0 || i == 32), (i % 8 == 7), sent[i]);
      end
    end
    n_chk++;
    if ({frame_cnt, ovf_err} !== {16'd2, 1'b0}) begin
      n_fail++; $display("FAIL basic_status: got fcnt=%0d ovf=%b, expected 2 0", frame_cnt, ovf_err);
    end
  endtask

  task automatic test_pre_vs();
    apply_reset();
    axis_tready = 1;
    send_line(5, 0); idle(3); send_line(5, 0); idle(6);
    n_chk++;
    if (obs.size() != 0) begin
      n_fail++; $display("FAIL prevs_dropped: got %0d beats, expected 0", obs.size());
    end
    send_frame(2, 8, 3);
    idle(20);
    n_chk++;
    if (obs.size() != 16) begin
      n_fail++; $display("FAIL prevs_count: got %0d beats, expected 16", obs.size());
    end else begin
      n_chk++;
      if ({obs[0].tuser, obs[0].rgb} !== {1'b1, sent[0]}) begin
        n_fail++;
        $display("FAIL prevs_first: got user=%b rgb=%h, expected 1 %h", obs[0].tuser, obs[0].rgb, sent[0]);
      end
    end
  endtask

  task automatic test_overflow();
    int n;
    apply_reset();
    axis_tready = 1;
    fork
      send_frame(4, 8, 1);
      begin
        repeat (10) tick();
        axis_tready = 0;
        repeat (20) tick();
        axis_tready = 1;
      end
    join
    send_frame(1, 8, 4);
    idle(24);
    n = obs.size();
    n_chk++;
    if (ovf_err !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b, expected 1", ovf_err);
    end
    n_chk++;
    if (n < 8 || n >= 40) begin
      n_fail++; $display("FAIL ovf_loss: got %0d beats, expected 8..39", n);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if ({obs[n-8+i].tuser, obs[n-8+i].rgb} !== {(i == 0), sent[32+i]}) begin
          n_fail++;
          $display("FAIL ovf_next_frame%0d: got user=%b rgb=%h, expected %b %h",
                   i, obs[n-8+i].tuser, obs[n-8+i].rgb, (i == 0), sent[32+i]);
        end
      end
    end
    tick(); ovf_clr = 1;
    tick(); ovf_clr = 0;
    n_chk++;
    if (ovf_err !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b, expected 0", ovf_err);
    end
  endtask

  task automatic test_full_pushpop();
    bit got;
    apply_reset();
    axis_tready = 0;
    got = 0;
    fork
      send_frame(1, 60, 4);
      begin
        for (int k = 0; k < 100 && !got; k++) begin
          tick();
          if (m_q.size() >= DEPTH) begin
            axis_tready = 1; got = 1;
          end
        end
        n_chk++;
        if (!got) begin
          n_fail++; $display("FAIL full_timeout: got not full after 100 cycles, expected full");
        end
        repeat (10) tick();
        n_chk++;
        if (ovf_err !== 1'b0) begin
          n_fail++; $display("FAIL full_pushpop: got ovf=%b, expected 0", ovf_err);
        end
        for (int k = 0; k < 10; k++) begin
          tick();
          axis_tready = (k % 2 == 1);
        end
        tick();
        axis_tready = 1;
      end
    join
    idle(24);
    n_chk++;
    if (ovf_err !== 1'b1) begin
      n_fail++; $display("FAIL full_slow_pop: got ovf=%b, expected 1", ovf_err);
    end
    n_chk++;
    if (obs.size() < DEPTH + 10 || obs.size() >= 60) begin
      n_fail++; $display("FAIL full_count: got %0d beats, expected %0d..59", obs.size(), DEPTH + 10);
    end else begin
      for (int i = 0; i < DEPTH + 10; i++) begin
        n_chk++;
        if (obs[i].rgb !== sent[i]) begin
          n_fail++; $display("FAIL full_data%0d: got %h, expected %h", i, obs[i].rgb, sent[i]);
        end
      end
    end
  endtask

  task automatic test_single_pixel();
    logic [23:0] r;
    apply_reset();
    axis_tready = 1;
    r = 24'($urandom);
    put(1, 0, 24'h0);
    put(0, 1, r);
    idle(10);
    n_chk++;
    if (obs.size() != 1) begin
      n_fail++; $display("FAIL single_count: got %0d beats, expected 1", obs.size());
    end else begin
      n_chk++;
      if ({obs[0].tuser, obs[0].tlast, obs[0].rgb} !== {2'b11, r}) begin
        n_fail++;
        $display("FAIL single_beat: got user=%b last=%b rgb=%h, expected 1 1 %h",
                 obs[0].tuser, obs[0].tlast, obs[0].rgb, r);
      end
    end
  endtask

  task automatic test_line_check();
    bit exp_err;
`ifdef LCD_IN_LINE_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    apply_reset();
    axis_tready = 1;
    put(1, 0, 24'h0);
    idle(2);
    send_line(8, 1); idle(6);
    n_chk++;
    if (line_err !== 1'b0) begin
      n_fail++; $display("FAIL line_ok: got %b, expected 0", line_err);
    end
    send_line(7, 1); idle(6);
    n_chk++;
    if (line_err !== exp_err) begin
      n_fail++; $display("FAIL line_short: got %b, expected %b", line_err, exp_err);
    end
    send_line(8, 1); idle(6);
    n_chk++;
    if (line_err !== exp_err) begin
      n_fail++; $display("FAIL line_sticky: got %b, expected %b", line_err, exp_err);
    end
    tick(); ovf_clr = 1;
    tick(); ovf_clr = 0;
    n_chk++;
    if (line_err !== 1'b0) begin
      n_fail++; $display("FAIL line_clear: got %b, expected 0", line_err);
    end
  endtask

  initial begin
    rst_n = 0; vin_vs = 0; vin_hs = 0; vin_de = 0; vin_rgb = '0;
    axis_tready = 1; ovf_clr = 0;
    test_reset();
    test_basic_frames();
    test_pre_vs();
    test_overflow();
    test_full_pushpop();
    test_single_pixel();
    test_line_check();
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
